// File: rtl/core_axil_bridge.sv
// core_axil_bridge: core native memory port to AXI4-Lite master bridge.
// One outstanding transaction, response timeout with bus drain, and a
// local auto-incrementing stream pointer window.
module core_axil_bridge #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STREAM_TAG  = ADDR_W'(32'hA0A00B08),
  parameter logic [ADDR_W-1:0] STREAM_DATA = STREAM_TAG + ADDR_W'(4),
  parameter int unsigned       STREAM_STEP = 4,
  parameter int unsigned       TIMEOUT     = 1024,
  parameter logic [31:0]       ERR_RDATA   = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              resetn,
  // core native port
  input  logic              mem_valid,
  input  logic              mem_instr,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  // AXI4-Lite AW
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI4-Lite W
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  // AXI4-Lite B
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI4-Lite AR
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI4-Lite R
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // status
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_BWAIT = 3'd2,
    S_AR    = 3'd3,
    S_RWAIT = 3'd4,
    S_RESP  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_axi_addr, w_axi_addr_nxt;
  logic [31:0]       r_wdata,    w_wdata_nxt;
  logic [3:0]        r_wstrb,    w_wstrb_nxt;
  logic [2:0]        r_arprot,   w_arprot_nxt;
  logic              r_awvalid,  w_awvalid_nxt;
  logic              r_wvalid,   w_wvalid_nxt;
  logic              r_bready,   w_bready_nxt;
  logic              r_arvalid,  w_arvalid_nxt;
  logic              r_rready,   w_rready_nxt;
  logic              r_mem_ready, w_mem_ready_nxt;
  logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
  logic              r_err,      w_err_nxt;
  logic [ADDR_W-1:0] r_err_addr, w_err_addr_nxt;
  logic [ADDR_W-1:0] r_ptr,      w_ptr_nxt;
  logic              r_stream,   w_stream_nxt;
  logic              r_is_wr,    w_is_wr_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic              r_busy,     w_busy_nxt;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_waiting, w_tmo, w_unused;

  assign w_aw_hs   = r_awvalid & awready;
  assign w_w_hs    = r_wvalid  & wready;
  assign w_ar_hs   = r_arvalid & arready;
  assign w_waiting = (r_state == S_WR) || (r_state == S_BWAIT) ||
                     (r_state == S_AR) || (r_state == S_RWAIT);
  // Counter holds the cycle number since accept; fire on the cycle that would reach TIMEOUT.
  assign w_tmo     = (TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) >= TIMEOUT);
  assign w_unused  = ^{bresp[0], rresp[0]};

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_axi_addr_nxt  = r_axi_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_arprot_nxt    = r_arprot;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_mem_ready_nxt = 1'b0;
    w_mem_rdata_nxt = r_mem_rdata;
    w_err_nxt       = 1'b0;
    w_err_addr_nxt  = r_err_addr;
    w_ptr_nxt       = r_ptr;
    w_stream_nxt    = r_stream;
    w_is_wr_nxt     = r_is_wr;
    w_cnt_nxt       = r_cnt;

    if (w_waiting) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (mem_valid) begin
          w_wdata_nxt  = mem_wdata;
          w_wstrb_nxt  = mem_wstrb;
          w_arprot_nxt = {mem_instr, 2'b00};
          w_is_wr_nxt  = (mem_wstrb != 4'b0000);
          w_cnt_nxt    = CNT_W'(1);
          w_stream_nxt = 1'b0;
          if (mem_addr == STREAM_TAG) begin
            w_state_nxt     = S_RESP;
            w_mem_ready_nxt = 1'b1;
            if (mem_wstrb != 4'b0000) begin
              w_ptr_nxt = mem_wdata;
            end else begin
              w_mem_rdata_nxt = r_ptr;
            end
          end else begin
            w_stream_nxt   = (mem_addr == STREAM_DATA);
            w_axi_addr_nxt = (mem_addr == STREAM_DATA) ? r_ptr : mem_addr;
            if (mem_wstrb != 4'b0000) begin
              w_state_nxt   = S_WR;
              w_awvalid_nxt = 1'b1;
              w_wvalid_nxt  = 1'b1;
            end else begin
              w_state_nxt   = S_AR;
              w_arvalid_nxt = 1'b1;
            end
          end
        end
      end
      S_WR: begin
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs)  w_wvalid_nxt  = 1'b0;
        if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
          w_state_nxt  = S_BWAIT;
          w_bready_nxt = 1'b1;
        end
      end
      S_BWAIT: begin
        if (bvalid) begin
          w_bready_nxt    = 1'b0;
          w_state_nxt     = S_RESP;
          w_mem_ready_nxt = 1'b1;
          if (bresp[1]) begin
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = r_axi_addr;
          end
        end
      end
      S_AR: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (rvalid) begin
          w_rready_nxt    = 1'b0;
          w_state_nxt     = S_RESP;
          w_mem_ready_nxt = 1'b1;
          if (rresp[1]) begin
            w_mem_rdata_nxt = ERR_RDATA;
            w_err_nxt       = 1'b1;
            w_err_addr_nxt  = r_axi_addr;
          end else begin
            w_mem_rdata_nxt = rdata;
          end
        end
      end
      S_RESP: begin
        w_state_nxt  = S_IDLE;
        w_stream_nxt = 1'b0;
        if (r_stream) begin
          w_ptr_nxt = r_ptr + ADDR_W'(STREAM_STEP);
        end
      end
      S_DRAIN: begin
        // Finish whatever handshakes remain, then swallow the response.
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs)  w_wvalid_nxt  = 1'b0;
        if (w_ar_hs) w_arvalid_nxt = 1'b0;
        if (r_is_wr) begin
          if (r_bready && bvalid) begin
            w_bready_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end else if (!w_awvalid_nxt && !w_wvalid_nxt) begin
            w_bready_nxt = 1'b1;
          end
        end else begin
          if (r_rready && rvalid) begin
            w_rready_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end else if (!w_arvalid_nxt) begin
            w_rready_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Timeout answers the core now but leaves the AXI transaction to finish in DRAIN.
    if (w_tmo && w_waiting && (w_state_nxt != S_RESP)) begin
      w_state_nxt     = S_DRAIN;
      w_mem_ready_nxt = 1'b1;
      w_mem_rdata_nxt = ERR_RDATA;
      w_err_nxt       = 1'b1;
      w_err_addr_nxt  = r_axi_addr;
      w_stream_nxt    = 1'b0;
      if (r_is_wr) begin
        w_bready_nxt = !w_awvalid_nxt && !w_wvalid_nxt;
        w_rready_nxt = 1'b0;
      end else begin
        w_rready_nxt = !w_arvalid_nxt;
        w_bready_nxt = 1'b0;
      end
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_axi_addr  <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_arprot    <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
      r_ptr       <= '0;
      r_stream    <= 1'b0;
      r_is_wr     <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_axi_addr  <= w_axi_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_arprot    <= w_arprot_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_mem_ready <= w_mem_ready_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_err       <= w_err_nxt;
      r_err_addr  <= w_err_addr_nxt;
      r_ptr       <= w_ptr_nxt;
      r_stream    <= w_stream_nxt;
      r_is_wr     <= w_is_wr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign awaddr    = r_axi_addr;
  assign awprot    = 3'b000;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign araddr    = r_axi_addr;
  assign arprot    = r_arprot;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign err       = r_err;
  assign err_addr  = r_err_addr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_core_axil_bridge.sv
// Bench for core_axil_bridge: directed steps plus a randomized run against
// a latency/address/pointer reference model and a delay-programmable AXI slave.
module tb_core_axil_bridge;

  localparam logic [31:0] TAG  = 32'hA0A00B08;
  localparam logic [31:0] SDAT = 32'hA0A00B0C;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] awaddr, araddr, wdata, rdata, err_addr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready, err, busy;

  int errors = 0;
  int checks = 0;

  // slave configuration
  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

  // slave state and logs
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, b_n = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_arprot = '0, last_awprot = '0;

  logic aw_hs_t, w_hs_t;

  core_axil_bridge #(.TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .err(err), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  assign awready = awvalid && (aw_wait >= cfg_aw_dly);
  assign wready  = wvalid  && (w_wait  >= cfg_w_dly);
  assign arready = arvalid && (ar_wait >= cfg_ar_dly);
  assign bvalid  = b_pend && (b_wait >= cfg_b_dly);
  assign rvalid  = r_pend && (r_wait >= cfg_r_dly);
  assign bresp   = cfg_bresp;
  assign rdata   = cfg_rdata;
  assign rresp   = cfg_rresp;
  assign aw_hs_t = awvalid && awready;
  assign w_hs_t  = wvalid && wready;

  // AXI-Lite slave with programmable per-channel wait cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (aw_hs_t) begin
        aw_wait <= 0; aw_n <= aw_n + 1; last_awaddr <= awaddr; last_awprot <= awprot;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (w_hs_t) begin
        w_wait <= 0; w_n <= w_n + 1; last_wdata <= wdata; last_wstrb <= wstrb;
      end else if (wvalid) w_wait <= w_wait + 1;
      if (arvalid && arready) begin
        ar_wait <= 0; ar_n <= ar_n + 1; last_araddr <= araddr; last_arprot <= arprot;
        r_pend <= 1'b1; r_wait <= 0;
      end else if (arvalid) ar_wait <= ar_wait + 1;
      if (r_pend) begin
        if (rvalid && rready) begin r_pend <= 1'b0; r_n <= r_n + 1; end
        else if (!rvalid) r_wait <= r_wait + 1;
      end
      if (b_pend) begin
        if (bvalid && bready) begin b_pend <= 1'b0; b_n <= b_n + 1; end
        else if (!bvalid) b_wait <= b_wait + 1;
      end
      if ((aw_got || aw_hs_t) && (w_got || w_hs_t)) begin
        b_pend <= 1'b1; b_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_got || aw_hs_t; w_got <= w_got || w_hs_t;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One core request; lat = cycles from accept edge to the mem_ready cycle.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, output logic [31:0] rd, output int lat, output logic e);
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins; mem_valid = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_ready && lat < 200);
    rd = mem_rdata; e = err;
    mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, ax, mptr, exp_rd, addr, wd;
    logic [3:0]  ws;
    logic        e, is_wr, strm;
    int lat, t, a0, w0, r0, kind, exp_lat;
    int ad, wdl, bd, ard, rdl;
    logic [1:0]  rsp;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, err}), 64'd0);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait read
    cfg_rdata = 32'h12345678;
    do_req(32'h1000, '0, 4'b0000, 1'b0, rd, lat, e);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_data", 64'(rd), 64'h12345678);
    chk("rd_araddr", 64'(last_araddr), 64'h1000);
    chk("rd_arprot", 64'(last_arprot), 64'd0);
    chk("rd_err", 64'(e), 64'd0);

    // write with W handshake two cycles after AW
    cfg_w_dly = 2; a0 = aw_n; w0 = w_n;
    do_req(32'h2000, 32'hCAFEF00D, 4'b0011, 1'b0, rd, lat, e);
    chk("wr_lat", 64'(lat), 64'd5);
    chk("wr_aw_once", 64'(aw_n - a0), 64'd1);
    chk("wr_w_once", 64'(w_n - w0), 64'd1);
    chk("wr_wstrb", 64'(last_wstrb), 64'b0011);
    chk("wr_wdata", 64'(last_wdata), 64'hCAFEF00D);
    chk("wr_awaddr", 64'(last_awaddr), 64'h2000);
    chk("wr_awprot", 64'(last_awprot), 64'd0);
    chk("wr_err", 64'(e), 64'd0);
    cfg_w_dly = 0;

    // stream window
    do_req(TAG, 32'h3000, 4'b1111, 1'b0, rd, lat, e);
    chk("tag_wr_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 3; i++) begin
      do_req(SDAT, '0, 4'b0000, 1'b0, rd, lat, e);
      chk("stream_araddr", 64'(last_araddr), 64'(32'h3000 + 32'(4 * i)));
    end
    a0 = ar_n;
    do_req(TAG, '0, 4'b0000, 1'b0, rd, lat, e);
    chk("tag_rd_ptr", 64'(rd), 64'h300C);
    chk("tag_rd_no_ar", 64'(ar_n - a0), 64'd0);
    chk("tag_rd_lat", 64'(lat), 64'd1);

    // SLVERR read
    cfg_rresp = 2'b10;
    do_req(32'h4000, '0, 4'b0000, 1'b0, rd, lat, e);
    chk("slverr_rdata", 64'(rd), 64'(ERRD));
    chk("slverr_err", 64'(e), 64'd1);
    chk("slverr_err_addr", 64'(err_addr), 64'h4000);
    chk("slverr_err_pulse", 64'(err), 64'd0);
    cfg_rresp = 2'b00;

    // timeout with late rvalid, then a request held during the drain
    cfg_r_dly = 40; a0 = ar_n; r0 = r_n;
    mem_addr = 32'h6000; mem_wstrb = '0; mem_instr = 1'b1; mem_valid = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!mem_ready && t < 200);
    chk("tmo_lat", 64'(t), 64'd16);
    chk("tmo_rdata", 64'(mem_rdata), 64'(ERRD));
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_err_addr", 64'(err_addr), 64'h6000);
    chk("tmo_arprot", 64'(last_arprot), 64'b100);
    mem_addr = 32'h7000; mem_instr = 1'b0;
    do begin
      @(posedge clk); #1; t++;
      if (r_n != r0 && cfg_r_dly != 0) begin cfg_r_dly = 0; cfg_rdata = 32'h0BADF00D; end
      if (t == 30) begin
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_no_accept", 64'(ar_n - a0), 64'd1);
      end
    end while (!mem_ready && t < 200);
    chk("drain_next_lat", 64'(t), 64'd46);
    chk("drain_next_data", 64'(mem_rdata), 64'h0BADF00D);
    chk("drain_next_addr", 64'(last_araddr), 64'h7000);
    chk("drain_err_hold", 64'(err_addr), 64'h6000);
    mem_valid = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in BWAIT
    cfg_b_dly = 10;
    mem_addr = 32'h8000; mem_wdata = 32'h55AA55AA; mem_wstrb = 4'b1111; mem_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("bwait_bready", 64'(bready), 64'd1);
    #2 resetn = 1'b0;
    #1;
    mem_valid = 1'b0; mem_wstrb = '0;
    chk("arst_outs", 64'({bready, busy, mem_ready, err, awvalid, wvalid, arvalid, rready}), 64'd0);
    chk("arst_rdata", 64'(mem_rdata), 64'd0);
    chk("arst_err_addr", 64'(err_addr), 64'd0);
    chk("arst_addr", 64'(awaddr), 64'd0);
    cfg_b_dly = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    cfg_rdata = 32'h600DCAFE;
    do_req(32'h9000, '0, 4'b0000, 1'b0, rd, lat, e);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_data", 64'(rd), 64'h600DCAFE);

    // randomized traffic against the reference model
    mptr = '0;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 5);
      ad = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      cfg_aw_dly = ad; cfg_w_dly = wdl; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rdl;
      cfg_rdata = $urandom; rsp = 2'($urandom_range(0, 3));
      cfg_rresp = rsp; cfg_bresp = rsp;
      wd = $urandom;
      addr = 32'h0001_0000 + 32'($urandom_range(0, 1023) * 4);
      ws = 4'($urandom_range(1, 15));
      is_wr = (kind == 2) || (kind == 4) || (kind == 5 && wd[0]);
      strm = (kind == 3) || (kind == 4);
      if (kind == 5) addr = TAG;
      else if (strm) addr = SDAT;
      if (!is_wr) ws = 4'b0000;
      a0 = ar_n; w0 = w_n;
      do_req(addr, wd, ws, 1'b0, rd, lat, e);
      if (kind == 5) begin
        chk("rnd_tag_lat", 64'(lat), 64'd1);
        chk("rnd_tag_err", 64'(e), 64'd0);
        if (is_wr) mptr = wd;
        else chk("rnd_tag_rdata", 64'(rd), 64'(mptr));
      end else begin
        ax = strm ? mptr : addr;
        if (is_wr) begin
          exp_lat = 3 + ((ad > wdl) ? ad : wdl) + bd;
          chk("rnd_wr_awaddr", 64'(last_awaddr), 64'(ax));
          chk("rnd_wr_wdata", 64'({last_wstrb, last_wdata}), 64'({ws, wd}));
          chk("rnd_wr_w_once", 64'(w_n - w0), 64'd1);
        end else begin
          exp_lat = 3 + ard + rdl;
          exp_rd = rsp[1] ? ERRD : cfg_rdata;
          chk("rnd_rd_araddr", 64'(last_araddr), 64'(ax));
          chk("rnd_rd_data", 64'(rd), 64'(exp_rd));
          chk("rnd_rd_ar_once", 64'(ar_n - a0), 64'd1);
        end
        chk("rnd_lat", 64'(lat), 64'(exp_lat));
        chk("rnd_err", 64'(e), 64'(rsp[1]));
        if (rsp[1]) chk("rnd_err_addr", 64'(err_addr), 64'(ax));
        if (strm) mptr = mptr + 32'd4;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_axil_bridge.md
# core_axil_bridge

Parametrised bridge from the core's native memory port (valid/ready, byte strobes) to an AXI4-Lite master, one outstanding transaction. Successor to the single-port core-to-AXI adapter in `core_region`. Adds:
- full write-response (B) handling and error reporting;
- concurrent AW/W issue;
- a response timeout with safe bus drain;
- an auto-incrementing stream window at a tagged address.

## Interface
Parameters:
- ADDR_W, 32, AXI/core address width.
- STREAM_TAG, 32'hA0A00B08, pointer register address (local, never forwarded to AXI).
- STREAM_DATA, STREAM_TAG+4, stream window address; accesses are forwarded to AXI at the pointer value.
- STREAM_STEP, 4, pointer increment per completed stream access.
- TIMEOUT, 1024, cycles from accept to core response before error; 0 disables.
- ERR_RDATA, 32'hDEADBEEF, read data returned on error or timeout.

Ports (data width fixed at 32):
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  core request.
- mem_instr  in  1  instruction fetch qualifier.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- awaddr, awprot[3], awvalid, awready  AXI-Lite AW channel (master).
- wdata[32], wstrb[4], wvalid, wready  AXI-Lite W channel (master).
- bresp[2], bvalid, bready  AXI-Lite B channel (master).
- araddr, arprot[3], arvalid, arready  AXI-Lite AR channel (master).
- rdata[32], rresp[2], rvalid, rready  AXI-Lite R channel (master).
- err  out  1  one-cycle pulse on SLVERR/DECERR or timeout.
- err_addr  out  ADDR_W  AXI address of the last errored transaction; holds until the next error.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE, WR, BWAIT, AR, RWAIT, RESP, DRAIN.

- **IDLE, mem_valid=1, accept.** Latch addr/wdata/wstrb/instr.
  - Address == STREAM_TAG: local access, go to RESP.
    - Write: ptr <= mem_wdata.
    - Read: mem_rdata <= ptr.
  - Address == STREAM_DATA: AXI address = ptr; set stream flag.
  - Otherwise: AXI address = mem_addr.
  - wstrb != 0 goes to WR; wstrb == 0 goes to AR.
- **WR.** awvalid and wvalid assert together.
  - Each valid drops independently on its own handshake; aw_done and w_done are tracked separately.
  - When both are done, go to BWAIT.
- **BWAIT.** bready=1. On bvalid, go to RESP. err pulses if bresp[1]=1.
- **AR.** arvalid=1. On arready, go to RWAIT.
- **RWAIT.** rready=1. On rvalid, capture data and go to RESP.
  - rresp[1]=0: mem_rdata <= rdata.
  - rresp[1]=1: mem_rdata <= ERR_RDATA and err pulses.
- **RESP.** mem_ready=1 for exactly one cycle, then IDLE. On stream accesses, ptr += STREAM_STEP (mod 2^ADDR_W), including errored accesses.
- **Timeout.** A counter starts at accept. If it reaches TIMEOUT while in WR/BWAIT/AR/RWAIT:
  - mem_ready pulses with mem_rdata=ERR_RDATA and err pulses;
  - go to DRAIN. The AXI transaction is not aborted.
- **DRAIN.** Outstanding valids stay asserted until handshaken (AXI rule: valid never drops early). bready/rready are held until the response arrives and is discarded. Then IDLE. mem_valid is ignored meanwhile; ptr does not increment.
- **Protection.** awprot=3'b000. arprot={mem_instr,2'b00}.
- **Reset.** Asynchronous and mid-transaction: all valids/readies, mem_ready, err and busy go to 0; addresses, data, mem_rdata, err_addr and ptr go to 0; state goes to IDLE.

## Timing
- Accept edge is cycle 0. AXI valids are first high in cycle 1; no combinational path from mem_* to AXI outputs.
- Zero-wait slave: AXI read or write gives mem_ready in cycle 3. Each additional wait cycle on any channel adds one cycle.
- Local STREAM_TAG access gives mem_ready in cycle 1.
- A new request can be accepted in the cycle after mem_ready, since IDLE samples mem_valid. The core drops mem_valid on the mem_ready edge.
- awready and wready in different cycles (either order, or simultaneous): both are accepted; BWAIT is entered the cycle after the later one.
- bvalid/rvalid asserted early, before the address handshake: ignored until BWAIT/RWAIT.
- Timeout fires when the counter equals TIMEOUT. If the response arrives on that same edge, the normal response wins.

## Test plan
- Read 0x1000, zero-wait slave returning 0x12345678 -> mem_ready in cycle 3, mem_rdata=0x12345678, arprot=3'b000, err=0.
- Write 0x2000 data 0xCAFEF00D wstrb 4'b0011; wready arrives 2 cycles after awready -> AW and W each handshake once, wstrb=0011, mem_ready one cycle after bvalid.
- Stream window:
  - write STREAM_TAG 0x3000, then 3 reads of STREAM_DATA -> araddr 0x3000, 0x3004, 0x3008;
  - then read STREAM_TAG -> 0x300C with no AR issued.
- Slave returns rresp=SLVERR on 0x4000 -> mem_rdata=0xDEADBEEF, err pulses for 1 cycle, err_addr=0x4000.
- TIMEOUT=16, slave withholds rvalid for 40 cycles:
  - cycle 16: mem_ready pulses with 0xDEADBEEF and err pulses;
  - busy stays high until rvalid, and a request raised meanwhile is not accepted until IDLE.
- resetn low mid-BWAIT -> all outputs 0 immediately, without a clock edge; the next read then completes normally.
